// File: rtl/controller_op_stack_if.sv
// Operator-stack bus between the calculator controller and the operator stack.
//
// Handshake semantics (one-cycle command, no back-pressure):
//   op_push / op_pop / op_clear are sampled on the rising Clock edge only.
//   They are level commands that act for exactly one edge. The stack never stalls.
//   op_busy is high in the cycle after any edge that changed the count or the top entry.
//   A controller that needs a settled op_data waits for op_busy==0. In practice op_data
//   is already valid in the cycle op_busy is high.
//   op_din is only looked at when op_push is high. It may be X otherwise.
//
// Ports (master = controller, slave = stack):
//   op_push, op_pop, op_clear, op_din        : controller -> stack
//   op_data, op_empty, op_full, op_count,
//   op_ovf, op_unf, op_busy                  : stack -> controller
interface controller_op_stack_if #(
  parameter int CO_W  = 3,
  parameter int PTR_W = 4
);
  logic            op_push;
  logic            op_pop;
  logic            op_clear;
  logic [CO_W-1:0] op_din;
  logic [CO_W-1:0] op_data;
  logic            op_empty;
  logic            op_full;
  logic [PTR_W:0]  op_count;
  logic            op_ovf;
  logic            op_unf;
  logic            op_busy;

  modport master (
    output op_push, op_pop, op_clear, op_din,
    input  op_data, op_empty, op_full, op_count, op_ovf, op_unf, op_busy
  );

  modport slave (
    input  op_push, op_pop, op_clear, op_din,
    output op_data, op_empty, op_full, op_count, op_ovf, op_unf, op_busy
  );
endinterface

// File: rtl/controller_op_stack.sv
// LIFO of pending operator codes for shunting-yard evaluation in the calculator controller.
// The top of the stack is kept in a register (top_q), so op_data has zero read latency.
// op_data is valid in the cycle after the edge that changed the stack.
//
// Ports:
//   Clock : rising-edge clock
//   Reset : synchronous, active-low; empties the stack and clears the error flags
//   bus   : controller_op_stack_if.slave
//             push/pop/clear/din in
//             data/empty/full/count/ovf/unf/busy out
//
// Command priority per edge is Reset, then op_clear, then the push/pop combination.
// push+pop together replaces the top entry. On an empty stack it acts as a plain push.
module controller_op_stack #(
  parameter int CO_W  = 3,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input logic                  Clock,
  input logic                  Reset,
  controller_op_stack_if.slave bus
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE      = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] TWO      = (PTR_W+1)'(2);

  logic [CO_W-1:0]  mem [DEPTH];
  logic [PTR_W:0]   cnt, cnt_n;
  logic [CO_W-1:0]  top_q, top_n;
  logic             ovf_q, ovf_n;
  logic             unf_q, unf_n;
  logic             busy_q, busy_n;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic             is_empty, is_full;
  logic [PTR_W:0]   cnt_m1, cnt_m2;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == FULL_CNT);
  assign cnt_m1   = cnt - ONE;
  assign cnt_m2   = cnt - TWO;

  always_comb begin
    cnt_n  = cnt;
    top_n  = top_q;
    ovf_n  = ovf_q;
    unf_n  = unf_q;
    wr_en  = 1'b0;
    wr_idx = '0;
    if (bus.op_clear) begin
      cnt_n = '0;
      top_n = '0;
      ovf_n = 1'b0;
      unf_n = 1'b0;
    end else if (bus.op_push && !bus.op_pop) begin
      if (!is_full) begin
        wr_en  = 1'b1;
        wr_idx = cnt[PTR_W-1:0];
        cnt_n  = cnt + ONE;
        top_n  = bus.op_din;
      end else begin
        ovf_n = 1'b1;
      end
    end else if (!bus.op_push && bus.op_pop) begin
      if (!is_empty) begin
        cnt_n = cnt_m1;
        // The entry below the current top becomes the new top. Popping the last entry leaves 0.
        top_n = (cnt == ONE) ? '0 : mem[cnt_m2[PTR_W-1:0]];
      end else begin
        unf_n = 1'b1;
      end
    end else if (bus.op_push && bus.op_pop) begin
      if (!is_empty) begin
        // Replace the top in place. The count is unchanged.
        wr_en  = 1'b1;
        wr_idx = cnt_m1[PTR_W-1:0];
        top_n  = bus.op_din;
      end else begin
        // On an empty stack there is nothing to replace, so this is a plain push and not an underflow.
        wr_en  = 1'b1;
        wr_idx = '0;
        cnt_n  = ONE;
        top_n  = bus.op_din;
      end
    end
    busy_n = (cnt_n != cnt) || (top_n != top_q);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cnt    <= '0;
      top_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      top_q  <= top_n;
      ovf_q  <= ovf_n;
      unf_q  <= unf_n;
      busy_q <= busy_n;
    end
  end

  // Storage needs no reset. Entries above cnt are never observed.
  always_ff @(posedge Clock) begin
    if (Reset && wr_en) begin
      mem[wr_idx] <= bus.op_din;
    end
  end

  assign bus.op_data  = top_q;
  assign bus.op_empty = is_empty;
  assign bus.op_full  = is_full;
  assign bus.op_count = cnt;
  assign bus.op_ovf   = ovf_q;
  assign bus.op_unf   = unf_q;
  assign bus.op_busy  = busy_q;

endmodule

// File: doc/controller_op_stack.md
Name: controller_op_stack

Overview:
- LIFO store for operator codes in the calculator controller.
- Consumes the operator register output (operator_Q, written when operator_EN pulses) and holds pending operators for shunting-yard evaluation.
- Serves the top-of-stack back to the controller as op_data/op_empty, with push/pop/clear handshakes and sticky overflow/underflow errors.
- Sits beside the data stack, between the operator register and the precedence ROM / ALU sequencing.

Parameters:
- CO_W, 3, operator code width (matches the CO_* code width).
- DEPTH, 16, number of stack entries; power of two, at least 2.
- PTR_W, 4, log2(DEPTH); the pointer register is PTR_W+1 bits.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-low.
- op_push  input  1  push op_din this cycle.
- op_din  input  CO_W  code to push (from operator_Q).
- op_pop  input  1  discard the top entry this cycle.
- op_clear  input  1  empty the stack; errors are also cleared.
- op_data  output  CO_W  current top entry; 0 when empty.
- op_empty  output  1  stack holds 0 entries.
- op_full  output  1  stack holds DEPTH entries.
- op_count  output  PTR_W+1  number of entries held.
- op_ovf  output  1  sticky: push attempted while full.
- op_unf  output  1  sticky: pop attempted while empty.
- op_busy  output  1  high in the cycle after any state change; used by the controller to wait for op_data to settle.

Behaviour:
- Reset (Reset==0 at the clock edge):
  - count=0; op_ovf=op_unf=0; op_busy=0; op_data=0; op_empty=1; op_full=0.
  - Memory contents are don't-care.
  - Reset overrides all other inputs. Reset asserted mid-sequence discards all entries.
- Storage:
  - Register array mem[0..DEPTH-1] plus pointer cnt. Entry cnt-1 is the top.
  - op_data is driven from a registered top copy, so it is valid in the cycle after the edge that changed the stack. Zero-cycle read latency from then on.
- Priority per edge: Reset > op_clear > push/pop combination.
- op_clear=1: cnt<=0, op_ovf<=0, op_unf<=0, op_data<=0. push and pop are ignored.
- push=1, pop=0:
  - If not full: mem[cnt]<=op_din, cnt<=cnt+1, op_data<=op_din.
  - If full: no change to storage; op_ovf<=1.
- push=0, pop=1:
  - If not empty: cnt<=cnt-1, op_data<=mem[cnt-2], or 0 if cnt==1.
  - If empty: no change; op_unf<=1.
- push=1, pop=1 (replace top, used for the right-parenthesis/precedence replacement step):
  - If not empty: mem[cnt-1]<=op_din, cnt unchanged, op_data<=op_din.
  - If empty: acts as a plain push. op_unf is not set.
- Neither push nor pop: hold all state.
- op_busy<=1 when the edge changed cnt or the top entry; otherwise op_busy<=0.
- Flags are combinational from cnt:
  - op_empty=(cnt==0)
  - op_full=(cnt==DEPTH)
  - op_count=cnt
- No pointer wrap: cnt saturates between 0 and DEPTH. Full and empty are never simultaneous.
- op_ovf and op_unf stay set until op_clear or Reset.
- Inputs are sampled only at the edge. X on op_din while op_push=0 must not propagate.

Test Plan:
- Reset then idle → op_empty=1, op_count=0, op_data=0, op_ovf=op_unf=0 for 5 cycles.
- Push 3,1,4 on consecutive cycles (CO_W=3) → op_count=3, op_data=4. Pop three times → op_data sequence 1,3,0 and op_empty=1 after the third pop.
- Push 16 entries (values i mod 8), then push 7 → op_full=1, op_ovf=1, op_count=16, op_data=7 (i=15 value) unchanged. Pop on an empty stack → op_unf=1 and op_count stays 0.
- Stack [2,5], push=pop=1 with op_din=6 → op_count=2, op_data=6. Pop → op_data=2. Push=pop=1 on an empty stack with op_din=3 → op_count=1, op_unf=0.
- Stack with 4 entries and op_ovf=1; assert op_clear together with push=1 → op_count=0, op_ovf=0, op_data=0, and no push occurs.
- Push 2 entries, then drive Reset=0 for one cycle with push=1 → op_count=0, op_empty=1, flags cleared. op_busy is 1 exactly in the cycles following the push edges.
